// File: rtl/if_tracker.sv
// Fetch-stage trace source: timestamps granted instruction fetches and emits one trace element per returned fetch.
// Build option: define IF_TRACKER_GNT_WAIT_EN to start the timestamp at the first request cycle instead of the grant cycle.
package if_tracker_pkg;
    typedef struct packed {
        int time_start;
        int time_end;
    } stage_data_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        pass_through;
        stage_data_t if_data;
        stage_data_t id_data;
        stage_data_t ex_data;
        stage_data_t wb_data;
    } trace_output_t;
endpackage

module if_tracker #(
    parameter int  INSTR_ADDR_WIDTH = 32,
    parameter int  PENDING_DEPTH    = 4,
    parameter type trace_output     = if_tracker_pkg::trace_output_t
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [31:0]          counter,
    input  logic                        instr_req,
    input  logic                        instr_gnt,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic                        instr_rvalid,
    output trace_output                 if_data_o,
    output logic                        if_data_valid,
    output logic                        overflow,
    output logic                        spurious_rvalid
);

    localparam int PW = (PENDING_DEPTH > 1) ? $clog2(PENDING_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_L = PENDING_DEPTH[PW:0];

    typedef enum logic {IDLE, REQ_WAIT} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_push;
    logic signed [31:0]          w_push_start;
`ifdef IF_TRACKER_GNT_WAIT_EN
    logic signed [31:0]          r_start;
    logic                        w_latch;
`endif

    logic [INSTR_ADDR_WIDTH-1:0] r_q_addr  [PENDING_DEPTH];
    logic signed [31:0]          r_q_start [PENDING_DEPTH];
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [PW:0]                 r_count;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_do_push;
    logic                        w_do_pop;
    trace_output                 w_elem;
    trace_output                 r_out;
    logic                        r_valid;
    logic                        r_ovf;
    logic                        r_spur;

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_start = counter;
`ifdef IF_TRACKER_GNT_WAIT_EN
        w_latch      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (instr_req) begin
                    if (instr_gnt) begin
                        w_push = 1'b1;
                    end else begin
                        w_state_nxt = REQ_WAIT;
`ifdef IF_TRACKER_GNT_WAIT_EN
                        w_latch     = 1'b1;
`endif
                    end
                end
            end
            REQ_WAIT: begin
                if (instr_gnt) begin
                    w_push      = 1'b1;
`ifdef IF_TRACKER_GNT_WAIT_EN
                    w_push_start = r_start;
`endif
                    w_state_nxt = IDLE;
                end else if (!instr_req) begin
                    // request withdrawn before grant: nothing to trace
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef IF_TRACKER_GNT_WAIT_EN
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_start <= counter;
        end
    end
`endif

    assign w_full    = (r_count == DEPTH_L);
    assign w_empty   = (r_count == '0);
    assign w_do_push = w_push && !w_full;
    assign w_do_pop  = instr_rvalid && !w_empty;

    // Entry storage carries no reset; occupancy is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_q_addr[r_wr_ptr]  <= instr_addr;
            r_q_start[r_wr_ptr] <= w_push_start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_elem                    = '0;
        w_elem.addr               = r_q_addr[r_rd_ptr];
        w_elem.pass_through       = 1'b0;
        w_elem.if_data.time_start = r_q_start[r_rd_ptr];
        w_elem.if_data.time_end   = counter;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_spur  <= 1'b0;
        end else begin
            r_valid <= w_do_pop;
            if (w_do_pop) begin
                r_out <= w_elem;
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (instr_rvalid && w_empty) begin
                r_spur <= 1'b1;
            end
        end
    end

    assign if_data_o       = r_out;
    assign if_data_valid   = r_valid;
    assign overflow        = r_ovf;
    assign spurious_rvalid = r_spur;

endmodule
